// File: rtl/regfile_write_commit.sv
// Write-side driver for the physical register file: in-order FIFO of up to two results per cycle,
// drained two per cycle onto the write ports under commit_allow. Define READ_BYPASS_EN for the bypass lookup.
module regfile_write_commit #(
  parameter int DEPTH  = 8,
  parameter int SEL_W  = 6,
  parameter int DATA_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [1:0]                   in_valid,
  output logic                         in_ready,
  input  logic [SEL_W-1:0]             in_sel0,
  input  logic [SEL_W-1:0]             in_sel1,
  input  logic [DATA_W-1:0]            in_data0,
  input  logic [DATA_W-1:0]            in_data1,
  input  logic                         commit_allow,
  output logic [1:0]                   wr_ack,
  output logic [SEL_W-1:0]             wr_sel0,
  output logic [SEL_W-1:0]             wr_sel1,
  output logic [DATA_W-1:0]            wr_data0,
  output logic [DATA_W-1:0]            wr_data1,
  output logic                         wr_commit,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  input  logic [SEL_W-1:0]             byp_sel,
  output logic                         byp_hit,
  output logic [DATA_W-1:0]            byp_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SEL_W-1:0]  memSel  [DEPTH];
  logic [DATA_W-1:0] memData [DEPTH];

  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] freeSlots;
  logic             lane0Ok;
  logic             lane1Ok;
  logic             doPush;
  logic             doPop;
  logic [1:0]       pushCnt;
  logic [1:0]       popCnt;
  logic [1:0]       ackNext;
  logic [PTR_W-1:0] lane1Ptr;
  logic [PTR_W-1:0] rdPtrNext;

  assign fifo_count = count;
  assign freeSlots  = CNT_W'(DEPTH) - count;
  assign in_ready   = en & (freeSlots >= CNT_W'(2));

  // Writes to r0 are dropped at the door; they never occupy a slot.
  assign lane0Ok   = in_valid[0] & (in_sel0 != '0);
  assign lane1Ok   = in_valid[1] & (in_sel1 != '0);
  assign doPush    = in_ready;
  assign doPop     = en & commit_allow;
  assign pushCnt   = doPush ? ({1'b0, lane0Ok} + {1'b0, lane1Ok}) : 2'd0;
  assign popCnt    = !doPop ? 2'd0 : ((count >= CNT_W'(2)) ? 2'd2 : count[1:0]);
  assign ackNext   = {popCnt == 2'd2, popCnt != 2'd0};
  assign lane1Ptr  = wrPtr + PTR_W'(lane0Ok);
  assign rdPtrNext = rdPtr + PTR_W'(1);

  // Storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge clk) begin
    if (doPush) begin
      if (lane0Ok) begin
        memSel[wrPtr]  <= in_sel0;
        memData[wrPtr] <= in_data0;
      end
      if (lane1Ok) begin
        memSel[lane1Ptr]  <= in_sel1;
        memData[lane1Ptr] <= in_data1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      wr_ack    <= '0;
      wr_sel0   <= '0;
      wr_sel1   <= '0;
      wr_data0  <= '0;
      wr_data1  <= '0;
      wr_commit <= 1'b0;
    end else if (en) begin
      wrPtr     <= wrPtr + PTR_W'(pushCnt);
      rdPtr     <= rdPtr + PTR_W'(popCnt);
      count     <= count + CNT_W'(pushCnt) - CNT_W'(popCnt);
      wr_ack    <= ackNext;
      wr_commit <= |ackNext;
      if (ackNext[0]) begin
        wr_sel0  <= memSel[rdPtr];
        wr_data0 <= memData[rdPtr];
      end
      if (ackNext[1]) begin
        wr_sel1  <= memSel[rdPtrNext];
        wr_data1 <= memData[rdPtrNext];
      end
    end
  end

`ifdef READ_BYPASS_EN
  logic [DEPTH-1:0]  entryHit;
  logic [DATA_W-1:0] entryData [DEPTH];

  // gi is age order: 0 is the oldest occupied slot.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byp
    logic [PTR_W-1:0] idx;
    assign idx           = rdPtr + PTR_W'(gi);
    assign entryHit[gi]  = (CNT_W'(gi) < count) && (memSel[idx] == byp_sel);
    assign entryData[gi] = memData[idx];
  end

  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (byp_sel != '0) begin
      // Scan oldest to newest so the last match, the youngest write, wins.
      if (wr_ack[0] && (wr_sel0 == byp_sel)) begin
        byp_hit  = 1'b1;
        byp_data = wr_data0;
      end
      if (wr_ack[1] && (wr_sel1 == byp_sel)) begin
        byp_hit  = 1'b1;
        byp_data = wr_data1;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (entryHit[i]) begin
          byp_hit  = 1'b1;
          byp_data = entryData[i];
        end
      end
    end
  end
`else
  logic unusedBypSel;
  assign unusedBypSel = ^byp_sel;
  assign byp_hit      = 1'b0;
  assign byp_data     = '0;
`endif

endmodule

// File: tb/tb_regfile_write_commit.sv
// Directed bench for regfile_write_commit: accepted writes queue up as expected port traffic,
// and a negedge monitor pops and compares whenever the write ports fire.
module tb_regfile_write_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [5:0]  in_sel0, in_sel1;
  logic [31:0] in_data0, in_data1;
  logic        commit_allow;
  logic [1:0]  wr_ack;
  logic [5:0]  wr_sel0, wr_sel1;
  logic [31:0] wr_data0, wr_data1;
  logic        wr_commit;
  logic [3:0]  fifo_count;
  logic [5:0]  byp_sel;
  logic        byp_hit;
  logic [31:0] byp_data;

  typedef struct packed {
    logic [5:0]  sel;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  logic [31:0] rfModel [64];
  logic        lastPop = 1'b0;
  int          total = 0;
  int          bad = 0;

  regfile_write_commit #(.DEPTH(8), .SEL_W(6), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_sel0(in_sel0), .in_sel1(in_sel1), .in_data0(in_data0), .in_data1(in_data1),
    .commit_allow(commit_allow), .wr_ack(wr_ack), .wr_sel0(wr_sel0), .wr_sel1(wr_sel1),
    .wr_data0(wr_data0), .wr_data1(wr_data1), .wr_commit(wr_commit), .fifo_count(fifo_count),
    .byp_sel(byp_sel), .byp_hit(byp_hit), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic checkPort(input string name, input logic [5:0] sel, input logic [31:0] data);
    wr_t e;
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got sel=%0d data=%0h want nothing pending", name, sel, data);
    end else begin
      e = expQ.pop_front();
      check(name, 64'({sel, data}), 64'({e.sel, e.data}));
    end
  endtask

  // Pop attempt is known from the bench's own inputs at the edge.
  always @(posedge clk) lastPop <= en && commit_allow;

  always @(negedge clk) begin
    if (reset && lastPop && wr_ack != 2'b00) begin
      check("commit_or", 64'(wr_commit), 64'(1));
      check("ack_shape", 64'(wr_ack == 2'b10), 64'(0));
      if (wr_ack[0]) checkPort("port0", wr_sel0, wr_data0);
      if (wr_ack[1]) checkPort("port1", wr_sel1, wr_data1);
      if (wr_ack[0]) rfModel[wr_sel0] = wr_data0;
      if (wr_ack[1]) rfModel[wr_sel1] = wr_data1;
    end
  end

  // One cycle of stimulus; entries expected to land are queued at the edge.
  task automatic cyc(input logic [1:0] v, input logic [5:0] s0, input logic [31:0] d0,
                     input logic [5:0] s1, input logic [31:0] d1, input logic ca, input logic expRdy);
    wr_t e;
    in_valid = v; in_sel0 = s0; in_data0 = d0; in_sel1 = s1; in_data1 = d1;
    commit_allow = ca;
    #1;
    check("in_ready", 64'(in_ready), 64'(expRdy));
    @(posedge clk);
    if (expRdy) begin
      if (v[0] && s0 != 6'd0) begin e.sel = s0; e.data = d0; expQ.push_back(e); end
      if (v[1] && s1 != 6'd0) begin e.sel = s1; e.data = d1; expQ.push_back(e); end
    end
    #1;
    in_valid = 2'b00;
  endtask

  task automatic idle(input logic ca);
    in_valid = 2'b00;
    commit_allow = ca;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; in_valid = 2'b00; commit_allow = 1'b0;
    in_sel0 = '0; in_sel1 = '0; in_data0 = '0; in_data1 = '0; byp_sel = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(wr_ack), 64'(0));
    check("rst_count", 64'(fifo_count), 64'(0));
    check("rst_commit", 64'(wr_commit), 64'(0));
    check("rst_byp_hit", 64'(byp_hit), 64'(0));
    check("rst_byp_data", 64'(byp_data), 64'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // 1: two lanes in, out on both ports two edges later
    cyc(2'b11, 6'd5, 32'hA, 6'd9, 32'hB, 1'b1, 1'b1);
    check("t1_count", 64'(fifo_count), 64'(2));
    check("t1_ack_early", 64'(wr_ack), 64'(0));
    idle(1'b1);
    check("t1_ack", 64'(wr_ack), 64'(3));
    check("t1_commit", 64'(wr_commit), 64'(1));
    check("t1_sel0", 64'(wr_sel0), 64'(5));
    check("t1_sel1", 64'(wr_sel1), 64'(9));
    idle(1'b1);
    check("t1_ack_clr", 64'(wr_ack), 64'(0));
    check("t1_commit_clr", 64'(wr_commit), 64'(0));

    // 2: fill to DEPTH, overflow push refused, drain in order
    for (int i = 0; i < 4; i++)
      cyc(2'b11, 6'(2*i+1), 32'h100 + 32'(2*i), 6'(2*i+2), 32'h101 + 32'(2*i), 1'b0, 1'b1);
    check("t2_full", 64'(fifo_count), 64'(8));
    cyc(2'b11, 6'd10, 32'h99, 6'd11, 32'h9A, 1'b0, 1'b0);
    check("t2_full_hold", 64'(fifo_count), 64'(8));
    for (int k = 0; k < 4; k++) begin
      idle(1'b1);
      check("t2_ack", 64'(wr_ack), 64'(3));
      check("t2_count", 64'(fifo_count), 64'(6 - 2*k));
    end
    idle(1'b0);
    check("t2_ack_clr", 64'(wr_ack), 64'(0));

    // 3: r0 lane discarded
    cyc(2'b11, 6'd0, 32'h55, 6'd3, 32'h77, 1'b0, 1'b1);
    check("t3_count", 64'(fifo_count), 64'(1));
    idle(1'b1);
    check("t3_ack", 64'(wr_ack), 64'(1));
    idle(1'b0);

    // 4: same register twice in one cycle, newer on port1
    cyc(2'b11, 6'd7, 32'h1, 6'd7, 32'h2, 1'b0, 1'b1);
    idle(1'b1);
    check("t4_ack", 64'(wr_ack), 64'(3));
    idle(1'b0);
    check("t4_r7", 64'(rfModel[7]), 64'(2));

    // 5: count 7 refuses a pair while popping, then push+pop balance
    cyc(2'b11, 6'd20, 32'h200, 6'd21, 32'h201, 1'b0, 1'b1);
    cyc(2'b11, 6'd22, 32'h202, 6'd23, 32'h203, 1'b0, 1'b1);
    cyc(2'b11, 6'd24, 32'h204, 6'd25, 32'h205, 1'b0, 1'b1);
    cyc(2'b01, 6'd26, 32'h206, 6'd0, 32'h0, 1'b0, 1'b1);
    check("t5_count7", 64'(fifo_count), 64'(7));
    cyc(2'b11, 6'd27, 32'h207, 6'd28, 32'h208, 1'b1, 1'b0);
    check("t5_count_pop", 64'(fifo_count), 64'(5));
    cyc(2'b11, 6'd29, 32'h209, 6'd30, 32'h20A, 1'b1, 1'b1);
    check("t5_count_bal", 64'(fifo_count), 64'(5));
    idle(1'b1);
    check("t5_c3", 64'(fifo_count), 64'(3));
    idle(1'b1);
    check("t5_c1", 64'(fifo_count), 64'(1));
    idle(1'b1);
    check("t5_c0", 64'(fifo_count), 64'(0));
    check("t5_single", 64'(wr_ack), 64'(1));
    idle(1'b0);

    // en=0 freezes everything, including wr_ack
    cyc(2'b11, 6'd12, 32'h300, 6'd13, 32'h301, 1'b0, 1'b1);
    cyc(2'b11, 6'd14, 32'h302, 6'd15, 32'h303, 1'b0, 1'b1);
    idle(1'b1);
    check("en_pre_ack", 64'(wr_ack), 64'(3));
    en = 1'b0;
    idle(1'b1);
    check("en0_ack_hold", 64'(wr_ack), 64'(3));
    check("en0_count_hold", 64'(fifo_count), 64'(2));
    check("en0_ready", 64'(in_ready), 64'(0));
    en = 1'b1;
    idle(1'b1);
    check("en1_count", 64'(fifo_count), 64'(0));
    idle(1'b0);

    // 6: bypass lookup
    cyc(2'b11, 6'd4, 32'h10, 6'd4, 32'h20, 1'b0, 1'b1);
    byp_sel = 6'd4; #1;
`ifdef READ_BYPASS_EN
    check("byp_fifo_hit", 64'(byp_hit), 64'(1));
    check("byp_fifo_data", 64'(byp_data), 64'(32'h20));
`else
    check("byp_off_hit", 64'(byp_hit), 64'(0));
    check("byp_off_data", 64'(byp_data), 64'(0));
`endif
    byp_sel = 6'd0; #1;
    check("byp_r0_hit", 64'(byp_hit), 64'(0));
    check("byp_r0_data", 64'(byp_data), 64'(0));
    byp_sel = 6'd4;
    cyc(2'b01, 6'd4, 32'h30, 6'd0, 32'h0, 1'b1, 1'b1);
    check("byp_ack", 64'(wr_ack), 64'(3));
`ifdef READ_BYPASS_EN
    check("byp_young_data", 64'(byp_data), 64'(32'h30));
`else
    check("byp_off_hit2", 64'(byp_hit), 64'(0));
`endif
    byp_sel = 6'd5; #1;
    check("byp_miss", 64'(byp_hit), 64'(0));
    byp_sel = 6'd4;
    idle(1'b1);
`ifdef READ_BYPASS_EN
    check("byp_port_hit", 64'(byp_hit), 64'(1));
    check("byp_port_data", 64'(byp_data), 64'(32'h30));
`else
    check("byp_off_hit3", 64'(byp_hit), 64'(0));
`endif
    idle(1'b0);
    byp_sel = 6'd0;

    // reset mid-drain drops wr_ack without a clock edge
    cyc(2'b11, 6'd16, 32'h400, 6'd17, 32'h401, 1'b0, 1'b1);
    cyc(2'b11, 6'd18, 32'h402, 6'd19, 32'h403, 1'b0, 1'b1);
    idle(1'b1);
    check("mid_ack", 64'(wr_ack), 64'(3));
    reset = 1'b0;
    #1;
    check("mid_rst_ack", 64'(wr_ack), 64'(0));
    check("mid_rst_commit", 64'(wr_commit), 64'(0));
    check("mid_rst_count", 64'(fifo_count), 64'(0));
    expQ.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_count", 64'(fifo_count), 64'(0));
    cyc(2'b01, 6'd6, 32'h66, 6'd0, 32'h0, 1'b0, 1'b1);
    idle(1'b1);
    check("post_rst_ack", 64'(wr_ack), 64'(1));
    idle(1'b0);

    check("queue_drained", 64'(expQ.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
